// File: rtl/dds_pkg.sv
// Shared types and arithmetic for the DDS sine LUT loader.
//   loader_state_t : loader FSM state encoding
//   sat_t          : saturated slope value plus overflow flag
//   sat_slope()    : shifts a sample delta and clamps it to a signed slope range
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    STREAM,
    WRAP,
    DONE
  } loader_state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_t;

  // delta is an exact (sign-extended) difference; the 64-bit working width keeps
  // the shift free of overflow so the clamp sees the true value.
  function automatic sat_t sat_slope(input logic signed [63:0] delta,
                                     input int shift,
                                     input int slope_bits);
    sat_t res;
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    shifted = delta <<< shift;
    hi      = (64'sd1 <<< (slope_bits - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (slope_bits - 1));
    res.ovf = 1'b0;
    res.val = shifted;
    if (shifted > hi) begin
      res.ovf = 1'b1;
      res.val = hi;
    end else if (shifted < lo) begin
      res.ovf = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/dds_lut_ram.sv
// Simple dual-port LUT RAM: one write port, one registered read port.
//   clk_i, rst_n_i : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o       : read port, 1-cycle latency, read-before-write
module dds_lut_ram
  import dds_pkg::*;
#(
  parameter int g_width     = 36,
  parameter int g_addr_bits = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   we_i,
  input  logic [g_addr_bits-1:0] waddr_i,
  input  logic [g_width-1:0]     wdata_i,
  input  logic [g_addr_bits-1:0] raddr_i,
  output logic [g_width-1:0]     rdata_o
);

  logic [g_width-1:0] mem [2**g_addr_bits];
  logic [g_width-1:0] rdata_d;
  logic [g_width-1:0] rdata_q;

  // Array write kept out of the reset block so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = mem[raddr_i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dds_lut_loader.sv
// DDS sine LUT loader: takes a stream of half-wave samples, computes the
// interpolation slope for each entry and writes {slope, sample} into the LUT RAM,
// which the DDS channels read through lut_addr_i / lut_data_o.
//   start_i / abort_i          : begin / cancel a table load
//   s_data_i, s_valid_i, s_ready_o : sample stream
//   busy_o, done_o, err_o, lut_valid_o : load status
//   lut_addr_i, lut_data_o     : DDS read port, 1-cycle latency
//
// state  | meaning
// IDLE   | waiting for start_i
// FIRST  | waiting for sample 0 (kept for the wrap slope), no write
// STREAM | each sample n writes entry n-1
// WRAP   | writes entry N-1 using the sign-flipped sample 0
// DONE   | one-cycle completion, table marked valid
module dds_lut_loader
  import dds_pkg::*;
#(
  parameter int g_lut_sample_bits = 18,
  parameter int g_lut_slope_bits  = 18,
  parameter int g_interp_shift    = 7,
  parameter int g_lut_size_log2   = 12
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic                                      start_i,
  input  logic                                      abort_i,
  input  logic [g_lut_sample_bits-1:0]              s_data_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      err_o,
  output logic                                      lut_valid_o,
  input  logic [g_lut_size_log2-1:0]                lut_addr_i,
  output logic [g_lut_sample_bits+g_lut_slope_bits-1:0] lut_data_o
);

  localparam int                   c_word_bits = g_lut_sample_bits + g_lut_slope_bits;
  localparam logic [g_lut_size_log2-1:0] c_last_idx = '1;

  loader_state_t                  state_q, state_d;
  logic [g_lut_size_log2-1:0]     idx_q, idx_d;
  logic signed [g_lut_sample_bits-1:0] s0_q, s0_d;
  logic signed [g_lut_sample_bits-1:0] prev_q, prev_d;
  logic signed [g_lut_sample_bits-1:0] s_in;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic                           lut_valid_q, lut_valid_d;

  logic                           transfer;
  logic                           we;
  logic [g_lut_size_log2-1:0]     waddr;
  logic [c_word_bits-1:0]         wdata;
  sat_t                           sat_stream;
  sat_t                           sat_wrap;
  logic                           sat_unused;

  assign s_in       = s_data_i;
  assign sat_stream = sat_slope(64'(s_in) - 64'(prev_q), g_interp_shift, g_lut_slope_bits);
  assign sat_wrap   = sat_slope(-64'(s0_q) - 64'(prev_q), g_interp_shift, g_lut_slope_bits);
  assign sat_unused = ^{sat_stream.val[63:g_lut_slope_bits], sat_wrap.val[63:g_lut_slope_bits]};

  assign s_ready_o = (state_q == FIRST) || (state_q == STREAM);
  assign transfer  = s_valid_i && s_ready_o;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s0_d        = s0_q;
    prev_d      = prev_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    lut_valid_d = lut_valid_q;
    we          = 1'b0;
    waddr       = idx_q - 1'b1;
    wdata       = {sat_stream.val[g_lut_slope_bits-1:0], prev_q};
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = FIRST;
          err_d       = 1'b0;
          lut_valid_d = 1'b0;
          idx_d       = '0;
          busy_d      = 1'b1;
        end
      end
      FIRST: begin
        if (abort_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (transfer) begin
          s0_d    = s_in;
          prev_d  = s_in;
          idx_d   = 1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (transfer) begin
          we     = 1'b1;
          err_d  = err_q | sat_stream.ovf;
          prev_d = s_in;
          idx_d  = idx_q + 1'b1;
          if (idx_q == c_last_idx) begin
            state_d = WRAP;
          end
        end
      end
      WRAP: begin
        if (abort_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          we      = 1'b1;
          waddr   = c_last_idx;
          wdata   = {sat_wrap.val[g_lut_slope_bits-1:0], prev_q};
          err_d   = err_q | sat_wrap.ovf;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        lut_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      s0_q        <= '0;
      prev_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lut_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s0_q        <= s0_d;
      prev_q      <= prev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lut_valid_q <= lut_valid_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign lut_valid_o = lut_valid_q;

  dds_lut_ram #(
    .g_width    (c_word_bits),
    .g_addr_bits(g_lut_size_log2)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .raddr_i(lut_addr_i),
    .rdata_o(lut_data_o)
  );

endmodule

// File: tb/tb_dds_lut_loader.sv
module tb_dds_lut_loader;

  localparam int SB = 18;
  localparam int SLB = 18;
  localparam int L = 4;
  localparam int N = 16;
  localparam int W = SB + SLB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort_s = 1'b0;
  logic [SB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, busy, done, err, lut_valid;
  logic [L-1:0]  lut_addr = '0;
  logic [W-1:0]  lut_data;

  always #5 clk = ~clk;

  dds_lut_loader #(
    .g_lut_sample_bits(SB),
    .g_lut_slope_bits (SLB),
    .g_interp_shift   (7),
    .g_lut_size_log2  (L)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .abort_i    (abort_s),
    .s_data_i   (s_data),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .lut_valid_o(lut_valid),
    .lut_addr_i (lut_addr),
    .lut_data_o (lut_data)
  );

  typedef struct {
    logic [L-1:0] addr;
    logic [W-1:0] word;
  } vec_t;

  vec_t         vt [N];
  int           smp [N];
  logic [W-1:0] exp_mem [N];
  logic         exp_err;
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference entry: slope = (b - a) * 2^7 clamped to 18-bit signed, sample = a.
  function automatic logic [W-1:0] ref_entry(input int a, input int b, output logic ovf);
    longint sl;
    sl  = (longint'(b) - longint'(a)) * 128;
    ovf = 1'b0;
    if (sl > 131071) begin sl = 131071; ovf = 1'b1; end
    if (sl < -131072) begin sl = -131072; ovf = 1'b1; end
    return {18'(sl), 18'(a)};
  endfunction

  task automatic build_model();
    logic o;
    exp_err = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      exp_mem[k] = ref_entry(smp[k], smp[k+1], o);
      exp_err    = exp_err | o;
    end
    exp_mem[N-1] = ref_entry(smp[N-1], -smp[0], o);
    exp_err      = exp_err | o;
  endtask

  task automatic verify_model(input string nm);
    for (int k = 0; k < N; k++) begin
      lut_addr = L'(k);
      tick();
      chk($sformatf("%s_entry%0d", nm, k), lut_data, exp_mem[k]);
    end
  endtask

  task automatic verify_table(input string nm);
    for (int k = 0; k < N; k++) begin
      lut_addr = vt[k].addr;
      tick();
      chk($sformatf("%s_entry%0d", nm, vt[k].addr), lut_data, vt[k].word);
    end
  endtask

  // Full load of smp[]; optional random valid gaps and a start_i pulse while busy.
  task automatic load(input bit gaps, input int start_at);
    int  sent;
    int  cyc;
    bit  pulsed;
    sent   = 0;
    cyc    = 0;
    pulsed = 0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (sent < N && cyc < 400) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = SB'(smp[sent]);
      start   = 1'b0;
      if (!pulsed && sent == start_at) begin
        start  = 1'b1;
        pulsed = 1;
      end
      chk("no_early_done", done, 0);
      if (s_valid && s_ready) sent++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (sent < N) chk("load_timeout", sent, N);
    chk("done_in_wrap", done, 0);
    tick();
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("lut_valid_after", lut_valid, 1);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] old3;
    logic         o;

    for (int i = 0; i < N; i++) begin
      vt[i].addr = L'(i);
      vt[i].word = {18'(1280), 18'(10 * i)};
    end
    vt[N-1].word = {18'(-19200), 18'(150)};

    // reset values
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lut_valid", lut_valid, 0);
    chk("rst_lut_data", lut_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // ramp, back-to-back
    for (int i = 0; i < N; i++) smp[i] = 10 * i;
    load(0, -1);
    chk("ramp_err", err, 0);
    lut_addr = 4'd5;
    tick();
    chk("read_addr5", lut_data, vt[5].word);
    verify_table("ramp");

    // saturation
    smp[0] = 0;
    for (int i = 1; i < N; i++) smp[i] = 2000;
    build_model();
    load(0, -1);
    chk("sat_err", err, 1);
    lut_addr = 4'd0;
    tick();
    chk("sat_entry0", lut_data, {18'(131071), 18'(0)});
    lut_addr = 4'd15;
    tick();
    chk("sat_entry15", lut_data, {18'(-131072), 18'(2000)});
    verify_model("sat");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_err", err, 0);
    chk("start_clears_valid", lut_valid, 0);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("abort_first_busy", busy, 0);

    // ramp with gaps and an ignored start while busy
    for (int i = 0; i < N; i++) smp[i] = 10 * i;
    load(1, 5);
    chk("gap_err", err, 0);
    verify_table("gap");

    // abort after 7 transfers
    for (int i = 0; i < N; i++) smp[i] = 100 * i + 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = SB'(smp[i]);
      tick();
    end
    s_valid = 1'b0;
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done, 0);
      chk("abort_lut_valid", lut_valid, 0);
      tick();
    end
    lut_addr = 4'd2;
    tick();
    chk("abort_partial_entry2", lut_data, ref_entry(205, 305, o));
    lut_addr = 4'd6;
    tick();
    chk("abort_kept_entry6", lut_data, vt[6].word);

    // random loads against the model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        smp[i] = (r == 0) ? int'($urandom_range(0, 1000)) - 500
                          : int'($urandom_range(0, 262143)) - 131072;
      build_model();
      load(r[0], -1);
      chk($sformatf("rand%0d_err", r), err, exp_err);
      verify_model($sformatf("rand%0d", r));
    end

    // read-before-write on entry 3
    old3 = exp_mem[3];
    for (int i = 0; i < N; i++) smp[i] = 7 * i - 50;
    build_model();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_valid = 1'b1;
      s_data  = SB'(smp[i]);
      if (i == 4) lut_addr = 4'd3;
      chk("rbw_s_ready", s_ready, 1);
      tick();
      if (i == 4) chk("rbw_old_data", lut_data, old3);
      if (i == 5) chk("rbw_new_data", lut_data, exp_mem[3]);
    end
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rbw_lut_valid", lut_valid, 1);
    verify_model("rbw");

    // async reset mid-STREAM
    for (int i = 0; i < N; i++) smp[i] = 10 * i;
    lut_addr = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = SB'(smp[i]);
      tick();
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_lut_valid", lut_valid, 0);
    chk("arst_lut_data", lut_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) smp[i] = 3 * i * i - 40;
    build_model();
    load(0, -1);
    chk("post_rst_err", err, exp_err);
    verify_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
